// File: rtl/display_refresh_scanner.sv
// Time-multiplexed digit scanner for a seven-segment display.
// Steps the active digit index and presents that digit's BCD nibble from a once-per-frame snapshot.
module display_refresh_scanner #(
  parameter int unsigned DIV        = 100000,
  parameter int unsigned NUM_DIGITS = 2,
  parameter int unsigned IDX_W      = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    blank_lz,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  output logic [IDX_W-1:0]        refreshcounter,
  output logic [3:0]              digit_bcd,
  output logic                    digit_blank,
  output logic                    frame_start
);

  localparam int unsigned PreW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PreW-1:0]  PreMax = PreW'(DIV - 1);
  localparam logic [IDX_W-1:0] IdxMax = IDX_W'(NUM_DIGITS - 1);

  logic [PreW-1:0]         r_prescaler;
  logic [IDX_W-1:0]        r_refreshcounter;
  logic [4*NUM_DIGITS-1:0] r_snapshot;
  logic                    r_primed;
  logic [3:0]              r_digit_bcd;
  logic                    r_digit_blank;
  logic                    r_frame_start;

  logic                    w_tick;
  logic                    w_wrap;
  logic [IDX_W-1:0]        w_idx_next;
  logic [4*NUM_DIGITS-1:0] w_snap_next;
  logic [3:0]              w_nibble;
  logic                    w_upper_zero;
  logic                    w_blank_next;

  always_comb begin
    w_tick      = en && r_primed && (r_prescaler == PreMax);
    w_wrap      = (r_refreshcounter == IdxMax);
    w_idx_next  = w_wrap ? '0 : r_refreshcounter + 1'b1;
    // A new frame samples the live value so both digits come from the same instant.
    w_snap_next = w_wrap ? bcd_in : r_snapshot;
  end

  // Select the upcoming digit and check whether it and every more-significant digit is zero.
  always_comb begin
    w_nibble     = 4'd0;
    w_upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == w_idx_next) begin
        w_nibble = w_snap_next[4*i +: 4];
      end
      if ((IDX_W'(i) >= w_idx_next) && (w_snap_next[4*i +: 4] != 4'd0)) begin
        w_upper_zero = 1'b0;
      end
    end
    w_blank_next = blank_lz && (w_idx_next != '0) && w_upper_zero;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prescaler      <= '0;
      r_refreshcounter <= '0;
      r_snapshot       <= '0;
      r_primed         <= 1'b0;
      r_digit_bcd      <= 4'd0;
      r_digit_blank    <= 1'b0;
      r_frame_start    <= 1'b0;
    end else if (!r_primed) begin
      // First cycle out of reset opens a frame on digit 0 regardless of en.
      r_refreshcounter <= '0;
      r_snapshot       <= bcd_in;
      r_primed         <= 1'b1;
      r_digit_bcd      <= bcd_in[3:0];
      r_digit_blank    <= 1'b0;
      r_frame_start    <= 1'b1;
    end else begin
      r_frame_start <= 1'b0;
      if (en) begin
        r_prescaler <= w_tick ? '0 : r_prescaler + 1'b1;
      end
      if (w_tick) begin
        r_refreshcounter <= w_idx_next;
        r_snapshot       <= w_snap_next;
        r_digit_bcd      <= w_nibble;
        r_digit_blank    <= w_blank_next;
        r_frame_start    <= w_wrap;
      end
    end
  end

  assign refreshcounter = r_refreshcounter;
  assign digit_bcd      = r_digit_bcd;
  assign digit_blank    = r_digit_blank;
  assign frame_start    = r_frame_start;

endmodule

// File: doc/display_refresh_scanner.md
Name: display_refresh_scanner

Overview:
- Time-multiplexing scanner for the seven-segment display path of the 0-99 counter.
- Divides the system clock into a digit-refresh tick and steps a digit index `refreshcounter` that drives the anode decoder directly.
- Presents the BCD nibble and blank flag for the active digit to the cathode/segment decoder.
- Latches the counter value once per display frame, so the two digits never show a torn value. Leading zeros can optionally be blanked.

Parameters:
- DIV, 100000, clock cycles per digit slot (1 kHz digit rate at 100 MHz); legal range 2..2^24.
- NUM_DIGITS, 2, number of multiplexed digits; legal range 2..8.
- IDX_W, 1, width of digit index; must equal ceil(log2(NUM_DIGITS)).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  scan enable; low freezes prescaler, index and outputs.
- blank_lz  input  1  1 = blank leading zero digits.
- bcd_in  input  4*NUM_DIGITS  live BCD value; digit 0 (ones) in bits [3:0].
- refreshcounter  output  IDX_W  active digit index to the anode decoder.
- digit_bcd  output  4  BCD nibble of the active digit.
- digit_blank  output  1  1 = active digit must be dark.
- frame_start  output  1  one-cycle pulse when index returns to 0 and a new snapshot is taken.

Behaviour:
- Reset (sync, active-high) sets:
  - prescaler = 0, refreshcounter = 0, snapshot = 0, primed = 0;
  - digit_bcd = 0, digit_blank = 0, frame_start = 0.
- Reset has priority over every other event, including a tick in the same cycle. Reset mid-frame abandons the frame immediately.
- Priming:
  - The first cycle with reset = 0 and primed = 0 loads snapshot ← bcd_in and digit_bcd ← bcd_in[3:0].
  - It computes digit_blank for index 0 (always 0), sets primed = 1 and pulses frame_start.
  - The prescaler does not advance in that cycle.
  - Priming is independent of en.
- Prescaler:
  - When en = 1 and primed = 1, it counts 0..DIV-1 and wraps to 0.
  - tick = (prescaler == DIV-1) && en && primed.
  - en = 0 holds the prescaler value. No partial reset.
- Index:
  - On tick, idx_next = (refreshcounter == NUM_DIGITS-1) ? 0 : refreshcounter+1.
  - refreshcounter ← idx_next.
  - Digit period is exactly DIV cycles; frame period is DIV*NUM_DIGITS cycles.
- Snapshot:
  - Loaded from bcd_in only on a tick with idx_next == 0 (and at priming). Otherwise it holds.
  - bcd_in changes mid-frame are invisible until the next frame.
- Data outputs, all registered and updated in the same edge as refreshcounter, so index and data are never skewed:
  - digit_bcd ← nibble idx_next of the new snapshot. When idx_next == 0 this is the freshly loaded bcd_in nibble.
  - digit_blank ← blank_lz && (idx_next != 0) && (nibbles idx_next..NUM_DIGITS-1 of the new snapshot are all 0).
  - Digit 0 is never blanked.
  - frame_start ← 1 for one cycle on a tick with idx_next == 0; otherwise 0.
- Nibbles above 9 pass through unchanged. They are not blanked and not flagged; they count as non-zero for blanking.
- blank_lz is sampled at each tick only. A change between ticks takes effect at the next digit slot.
- en = 0: all outputs and state hold their values; frame_start stays 0.
- Outputs change only on a tick, on reset, or at priming.

Test Plan:
- Reset then prime, DIV = 4, NUM_DIGITS = 2, bcd_in = 8'h42, blank_lz = 0:
  - → cycle 1 after reset low: frame_start = 1, refreshcounter = 0, digit_bcd = 2.
  - → 4 cycles later: refreshcounter = 1, digit_bcd = 4.
  - → 4 cycles later: refreshcounter = 0, digit_bcd = 2, frame_start = 1.
- Tear-free snapshot: bcd_in changes 8'h42 → 8'h57 while refreshcounter = 0:
  - → the following slot still shows digit_bcd = 4.
  - → next frame shows 7 then 5.
- Leading-zero blank: bcd_in = 8'h07, blank_lz = 1:
  - → idx 0: digit_bcd = 7, digit_blank = 0.
  - → idx 1: digit_bcd = 0, digit_blank = 1.
  - → with blank_lz = 0, idx 1 has digit_blank = 0.
  - → bcd_in = 8'h00, blank_lz = 1: idx 0 has digit_blank = 0.
- Enable freeze: drop en for 10 cycles at prescaler = 2:
  - → refreshcounter, digit_bcd and prescaler hold; no frame_start.
  - → after en = 1, the next tick occurs exactly 1 enabled cycle later.
- Reset mid-frame at refreshcounter = 1, prescaler = 3 (same cycle as a tick):
  - → next cycle refreshcounter = 0, digit_bcd = 0, frame_start = 0.
  - → the priming cycle then reloads from bcd_in.
- Parameter sweep, NUM_DIGITS = 4, IDX_W = 2, DIV = 3, bcd_in = 16'h0305, blank_lz = 1:
  - → index sequence 0,1,2,3,0 every 3 cycles.
  - → digits 5,0,3,0 with digit_blank 0,0,0,1.
